// File: rtl/io_bridge_if.sv
// io_bridge_if
//
// Peripheral-side bus of io_bridge: one latched request/response port fanned
// out to NUM_CHANNELS peripherals.
//
// Signals
//   io_request      bridge -> periph  request, held until the access completes
//   io_write        bridge -> periph  1 = write, 0 = read (valid with io_request)
//   io_channel      bridge -> periph  selected channel (top bits of io_index)
//   io_index        bridge -> periph  full register index inside the window
//   io_write_value  bridge -> periph  write data
//   io_ready        periph -> bridge  per-channel completion strobe
//   io_read_value   periph -> bridge  per-channel read data, channel c at slice c
//
// Modports: master (bridge side), slave (peripheral bank side).
interface io_bridge_if #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int INDEX_BITS    = 7,
    parameter int NUM_CHANNELS  = 4,
    parameter int CH_BITS       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
);
    logic                                  io_request;
    logic                                  io_write;
    logic [CH_BITS-1:0]                    io_channel;
    logic [INDEX_BITS-1:0]                 io_index;
    logic [IO_DATA_WIDTH-1:0]              io_write_value;
    logic [NUM_CHANNELS-1:0]               io_ready;
    logic [NUM_CHANNELS*IO_DATA_WIDTH-1:0] io_read_value;

    modport master (
        output io_request, io_write, io_channel, io_index, io_write_value,
        input  io_ready, io_read_value
    );

    modport slave (
        input  io_request, io_write, io_channel, io_index, io_write_value,
        output io_ready, io_read_value
    );
endinterface

// File: rtl/io_bridge.sv
// io_bridge
//
// Memory-mapped I/O bridge between the lisp_core data port, the data RAM and
// a bank of peripheral channels. Addresses whose bits [15:INDEX_BITS] equal
// IO_BASE are forwarded to a peripheral over a request/ready handshake; the
// core is stalled until the peripheral answers or a timeout expires, and the
// captured read data is returned the cycle after the completing (RESP) cycle.
// All other addresses pass straight through to the RAM with no added latency.
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   core_address        core data address
//   core_write_value    core write data
//   core_write_enable   core write strobe
//   core_read_value     read data to core (capture register or RAM data)
//   core_stall          core must hold its current access
//   mem_read_value      synchronous RAM read data
//   mem_write_enable    RAM write strobe, suppressed for I/O addresses
//   io                  peripheral bus (io_bridge_if master)
//   io_timeout          one-cycle pulse in the WAIT cycle that times out
//   timeout_count       saturating count of timeouts
module io_bridge #(
    parameter int                    WORD_SIZE      = 20,
    parameter int                    IO_DATA_WIDTH  = 16,
    parameter int                    INDEX_BITS     = 7,
    parameter logic [15-INDEX_BITS:0] IO_BASE       = 9'h1FF,
    parameter int                    NUM_CHANNELS   = 4,
    parameter int                    TIMEOUT_CYCLES = 15,
    parameter logic [WORD_SIZE-1:0]  ERROR_VALUE    = '1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WORD_SIZE-1:0] core_address,
    input  logic [WORD_SIZE-1:0] core_write_value,
    input  logic                 core_write_enable,
    output logic [WORD_SIZE-1:0] core_read_value,
    output logic                 core_stall,
    input  logic [WORD_SIZE-1:0] mem_read_value,
    output logic                 mem_write_enable,
    io_bridge_if.master          io,
    output logic                 io_timeout,
    output logic [7:0]           timeout_count
);
    localparam int CH_BITS  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int CNT_BITS = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                   state, state_next;
    logic [INDEX_BITS-1:0]    index_q;
    logic                     write_q;
    logic [IO_DATA_WIDTH-1:0] write_value_q;
    logic [WORD_SIZE-1:0]     capture_q;
    logic [CNT_BITS-1:0]      wait_cnt;
    logic                     request_q;
    logic                     last_io;

    logic                     hit;
    logic [CH_BITS-1:0]       new_channel;
    logic                     bad_channel;
    logic                     ready_sel;
    logic [IO_DATA_WIDTH-1:0] read_sel;
    logic                     latch_req;
    logic                     cap_load;
    logic [WORD_SIZE-1:0]     cap_value;
    logic                     cnt_clear;

    // Address bits above the 16-bit window and write data above the
    // peripheral width carry no meaning for this block.
    logic unused_bits;
    assign unused_bits = &{1'b0, core_address[WORD_SIZE-1:16],
                           core_write_value[WORD_SIZE-1:IO_DATA_WIDTH]};

    assign hit              = (core_address[15:INDEX_BITS] == IO_BASE);
    assign new_channel      = core_address[INDEX_BITS-1 -: CH_BITS];
    assign bad_channel      = ({1'b0, new_channel} >= (CH_BITS+1)'(NUM_CHANNELS));
    assign mem_write_enable = core_write_enable & ~hit;
    assign core_stall       = ((state == IDLE) & hit) | (state == WAIT);
    assign core_read_value  = last_io ? capture_q : mem_read_value;

    assign io.io_request     = request_q;
    assign io.io_write       = write_q;
    assign io.io_index       = index_q;
    assign io.io_channel     = index_q[INDEX_BITS-1 -: CH_BITS];
    assign io.io_write_value = write_value_q;

    // Only the latched channel's ready/data are looked at; other channels'
    // strobes are ignored.
    always_comb begin
        ready_sel = 1'b0;
        read_sel  = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (io.io_channel == CH_BITS'(c)) begin
                ready_sel = io.io_ready[c];
                read_sel  = io.io_read_value[c*IO_DATA_WIDTH +: IO_DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    // io_timeout is decoded here rather than registered so the pulse lands in
    // the last WAIT cycle and is suppressed when ready arrives in that cycle.
    always_comb begin
        state_next = state;
        latch_req  = 1'b0;
        cap_load   = 1'b0;
        cap_value  = capture_q;
        cnt_clear  = 1'b0;
        io_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (hit) begin
                    latch_req = 1'b1;
                    if (bad_channel) begin
                        state_next = RESP;
                        cap_load   = 1'b1;
                        cap_value  = ERROR_VALUE;
                    end else begin
                        state_next = WAIT;
                        cnt_clear  = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (ready_sel) begin
                    state_next = RESP;
                    if (!write_q) begin
                        cap_load  = 1'b1;
                        cap_value = WORD_SIZE'(read_sel);
                    end
                end else if (wait_cnt == CNT_BITS'(TIMEOUT_CYCLES - 1)) begin
                    state_next = RESP;
                    cap_load   = 1'b1;
                    cap_value  = ERROR_VALUE;
                    io_timeout = 1'b1;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_q       <= '0;
            write_q       <= 1'b0;
            write_value_q <= '0;
            capture_q     <= '0;
            wait_cnt      <= '0;
            request_q     <= 1'b0;
            last_io       <= 1'b0;
            timeout_count <= '0;
        end else begin
            if (latch_req) begin
                index_q       <= core_address[INDEX_BITS-1:0];
                write_q       <= core_write_enable;
                write_value_q <= core_write_value[IO_DATA_WIDTH-1:0];
            end
            if (cap_load) capture_q <= cap_value;
            if (cnt_clear)           wait_cnt <= '0;
            else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
            request_q <= (state_next == WAIT);
            last_io   <= (state == RESP);
            if (io_timeout && timeout_count != 8'hFF)
                timeout_count <= timeout_count + 8'd1;
        end
    end
endmodule
